pinger_tdoa_locator: RTL and testbench



---
 rtl/auv_pkg.sv | 21 ++
 rtl/tdoa_sat_shift.sv | 37 +++
 rtl/pinger_tdoa_locator.sv | 190 +++++++++++++++++++
 tb/tb_pinger_tdoa_locator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/auv_pkg.sv
// Shared definitions for the AUV pinger-tracking front end.
//   tdoa_state_t : capture FSM states
//   NUM_HYD      : hydrophone count (bit 0 = reference, 1..3 = x/y/z axes)
//   AX_X/Y/Z     : axis indices into the position vector
//   POS_W        : width of one signed position component
package auv_pkg;

  localparam int NUM_HYD = 4;
  localparam int AX_X    = 0;
  localparam int AX_Y    = 1;
  localparam int AX_Z    = 2;
  localparam int POS_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_HOLDOFF = 2'd3
  } tdoa_state_t;

endpackage

// File: rtl/tdoa_sat_shift.sv
// One axis of the TDOA arithmetic: signed difference of two timestamps,
// arithmetic right shift (floor), then saturation to a signed POS_W value.
// Ports:
//   stamp_ref : arrival stamp of the reference hydrophone
//   stamp_ax  : arrival stamp of the axis hydrophone
//   pos       : saturated two's-complement result (positive = axis heard first)
module tdoa_sat_shift
  import auv_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic [CNT_W-1:0] stamp_ref,
  input  logic [CNT_W-1:0] stamp_ax,
  output logic [POS_W-1:0] pos
);

  localparam logic signed [CNT_W:0] SAT_HI = (CNT_W+1)'(127);
  localparam logic signed [CNT_W:0] SAT_LO = (CNT_W+1)'(-128);

  logic signed [CNT_W:0] diff_s;
  logic signed [CNT_W:0] shifted_s;

  // Subtract in CNT_W+1 bits so every difference of two stamps is representable
  always_comb begin
    diff_s    = $signed({1'b0, stamp_ref}) - $signed({1'b0, stamp_ax});
    shifted_s = diff_s >>> SHIFT;
    if (shifted_s > SAT_HI) begin
      pos = 8'h7F;
    end else if (shifted_s < SAT_LO) begin
      pos = 8'h80;
    end else begin
      pos = shifted_s[POS_W-1:0];
    end
  end

endmodule

// File: rtl/pinger_tdoa_locator.sv
// Pinger TDOA locator: timestamps the first rising edge on each of four
// hydrophone detector lines, then produces per-axis signed 8-bit arrival
// leads of the x/y/z hydrophones over the reference hydrophone.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : arms the block; low forces IDLE and drops any capture
//   hyd_det[3:0]    : synchronous detector levels (0 = ref, 1..3 = x/y/z)
//   pinger_position : [0]=x, [1]=y, [2]=z signed estimates (held between results)
//   pos_valid       : one-cycle pulse when pinger_position updates
//   timeout         : one-cycle pulse when a capture is abandoned
//   busy            : high in every state except IDLE
module pinger_tdoa_locator
  import auv_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int WINDOW  = 4096,
  parameter int HOLDOFF = 1024,
  parameter int SHIFT   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_HYD-1:0]        hyd_det,
  output logic [2:0][POS_W-1:0]     pinger_position,
  output logic                      pos_valid,
  output logic                      timeout,
  output logic                      busy
);

  // The counter doubles as the holdoff timer, so HOLDOFF must fit in CNT_W.
  // Timeout fires on the edge at which the counter would reach WINDOW-1.
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 2);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
  localparam logic [NUM_HYD-1:0] ALL_HYD = {NUM_HYD{1'b1}};

  tdoa_state_t                     state_q, state_d;
  logic [NUM_HYD-1:0]              prev_q, prev_d;
  logic [NUM_HYD-1:0]              rise_q, rise_d;
  logic [NUM_HYD-1:0]              flags_q, flags_d;
  logic [CNT_W-1:0]                counter_q, counter_d;
  logic [NUM_HYD-1:0][CNT_W-1:0]   stamp_q, stamp_d;
  logic [2:0][POS_W-1:0]           pos_q, pos_d;
  logic                            pos_valid_q, pos_valid_d;
  logic                            timeout_q, timeout_d;
  logic                            busy_q, busy_d;
  logic [2:0][POS_W-1:0]           ax_pos_s;
  logic                            capt_all_s;
  logic                            rise_ok_s;

  for (genvar a = AX_X; a <= AX_Z; a++) begin : g_axis
    tdoa_sat_shift #(
      .CNT_W (CNT_W),
      .SHIFT (SHIFT)
    ) u_sat (
      .stamp_ref (stamp_q[0]),
      .stamp_ax  (stamp_q[a+1]),
      .pos       (ax_pos_s[a])
    );
  end

  // Next-state logic for the capture FSM, stamps, edge detector and outputs
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    counter_d   = counter_q;
    stamp_d     = stamp_q;
    pos_d       = pos_q;
    pos_valid_d = 1'b0;
    timeout_d   = 1'b0;
    prev_d      = hyd_det;
    capt_all_s  = ((flags_q | rise_q) == ALL_HYD);

    if (!enable) begin
      state_d = ST_IDLE;
      flags_d = {NUM_HYD{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_q != {NUM_HYD{1'b0}}) begin
            counter_d = {CNT_W{1'b0}};
            flags_d   = rise_q;
            for (int i = 0; i < NUM_HYD; i++) begin
              if (rise_q[i]) begin
                stamp_d[i] = {CNT_W{1'b0}};
              end else begin
                stamp_d[i] = stamp_q[i];
              end
            end
            // All four on one edge: nothing left to wait for
            if (rise_q == ALL_HYD) begin
              state_d = ST_COMPUTE;
            end else begin
              state_d = ST_CAPTURE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_CAPTURE: begin
          counter_d = counter_q + CNT_W'(1);
          flags_d   = flags_q | rise_q;
          for (int i = 0; i < NUM_HYD; i++) begin
            if (rise_q[i] && !flags_q[i]) begin
              stamp_d[i] = counter_q + CNT_W'(1);
            end else begin
              stamp_d[i] = stamp_q[i];
            end
          end
          // A completing edge wins over a simultaneous window expiry
          if (capt_all_s) begin
            state_d = ST_COMPUTE;
          end else if (counter_q == WIN_LAST) begin
            state_d   = ST_HOLDOFF;
            counter_d = {CNT_W{1'b0}};
            timeout_d = 1'b1;
          end else begin
            state_d = ST_CAPTURE;
          end
        end

        ST_COMPUTE: begin
          pos_d       = ax_pos_s;
          pos_valid_d = 1'b1;
          counter_d   = {CNT_W{1'b0}};
          state_d     = ST_HOLDOFF;
        end

        ST_HOLDOFF: begin
          if (counter_q == HOLD_LAST) begin
            state_d   = ST_IDLE;
            flags_d   = {NUM_HYD{1'b0}};
            counter_d = {CNT_W{1'b0}};
          end else begin
            counter_d = counter_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          flags_d = {NUM_HYD{1'b0}};
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);

    // The edge register feeds the FSM one cycle later, so edges are only
    // kept when the FSM will be in a state that listens to them.
    rise_ok_s = enable && ((state_d == ST_IDLE) || (state_d == ST_CAPTURE));
    if (rise_ok_s) begin
      rise_d = hyd_det & ~prev_q;
    end else begin
      rise_d = {NUM_HYD{1'b0}};
    end
  end

  // State, capture and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prev_q      <= {NUM_HYD{1'b1}};
      rise_q      <= {NUM_HYD{1'b0}};
      flags_q     <= {NUM_HYD{1'b0}};
      counter_q   <= {CNT_W{1'b0}};
      stamp_q     <= '0;
      pos_q       <= '0;
      pos_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      rise_q      <= rise_d;
      flags_q     <= flags_d;
      counter_q   <= counter_d;
      stamp_q     <= stamp_d;
      pos_q       <= pos_d;
      pos_valid_q <= pos_valid_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign pinger_position = pos_q;
  assign pos_valid       = pos_valid_q;
  assign timeout         = timeout_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_pinger_tdoa_locator.sv
// Self-checking bench for pinger_tdoa_locator. Two instances share stimulus:
// one with SHIFT=0 and one with SHIFT=2. Expected results are queued when a
// ping is driven and compared when pos_valid appears.
module tb_pinger_tdoa_locator;

  localparam int HOLDOFF = 1024;
  localparam int WINDOW  = 4096;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable = 1'b1;
  logic [3:0]      hyd_det = 4'b1111;
  logic [2:0][7:0] pos0, pos2;
  logic            v0, v2, t0, t2, b0, b2;

  int checks  = 0;
  int fails   = 0;
  int cyc     = 0;
  int tmo_cnt = 0;

  typedef struct packed {
    logic [31:0]     kexp;
    logic [2:0][7:0] p0;
    logic [2:0][7:0] p2;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  pinger_tdoa_locator #(.CNT_W(16), .WINDOW(WINDOW), .HOLDOFF(HOLDOFF), .SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .hyd_det(hyd_det),
    .pinger_position(pos0), .pos_valid(v0), .timeout(t0), .busy(b0)
  );

  pinger_tdoa_locator #(.CNT_W(16), .WINDOW(WINDOW), .HOLDOFF(HOLDOFF), .SHIFT(2)) u_dut_s2 (
    .clk(clk), .rst(rst), .enable(enable), .hyd_det(hyd_det),
    .pinger_position(pos2), .pos_valid(v2), .timeout(t2), .busy(b2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: lead of axis over reference, floor shift, saturate
  function automatic logic [7:0] model(input int t_ref, input int t_ax, input int sh);
    int d;
    d = (t_ref - t_ax) >>> sh;
    if (d > 127) return 8'h7F;
    else if (d < -128) return 8'h80;
    else return d[7:0];
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (t0 === 1'b1) tmo_cnt++;
    if (!rst && (v0 === 1'b1 || v2 === 1'b1)) begin
      checks++;
      if (v0 !== v2) begin
        fails++;
        $display("FAIL valid_agree: shift0=%b shift2=%b", v0, v2);
      end
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_valid: cycle=%0d pos=%h, none expected", cyc, pos0);
      end else begin
        e = sb.pop_front();
        checks++;
        if (cyc !== int'(e.kexp)) begin
          fails++;
          $display("FAIL valid_latency: got cycle %0d, expected %0d", cyc, e.kexp);
        end
        for (int a = 0; a < 3; a++) begin
          checks++;
          if (pos0[a] !== e.p0[a]) begin
            fails++;
            $display("FAIL pos_shift0[%0d]: got %h, expected %h", a, pos0[a], e.p0[a]);
          end
          checks++;
          if (pos2[a] !== e.p2[a]) begin
            fails++;
            $display("FAIL pos_shift2[%0d]: got %h, expected %h", a, pos2[a], e.p2[a]);
          end
        end
      end
    end
    if (v0 === 1'b1 && t0 === 1'b1) begin
      checks++; fails++;
      $display("FAIL valid_and_timeout: both high at cycle %0d", cyc);
    end
  end

  // Drive one ping with per-channel arrival offsets (cycles) and queue the result
  task automatic drive_ping(input int ta, input int tb, input int tc, input int td);
    int t[4];
    int tmax;
    exp_t x;
    t[0] = ta; t[1] = tb; t[2] = tc; t[3] = td;
    tmax = 0;
    for (int i = 0; i < 4; i++) if (t[i] > tmax) tmax = t[i];
    for (int n = 0; n <= tmax; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (n >= t[i]) hyd_det[i] = 1'b1;
      if (n == tmax) begin
        x.kexp = 32'(cyc + 3);
        for (int a = 0; a < 3; a++) begin
          x.p0[a] = model(t[0], t[a+1], 0);
          x.p2[a] = model(t[0], t[a+1], 2);
        end
        sb.push_back(x);
      end
    end
  endtask

  task automatic finish_ping();
    repeat (HOLDOFF + 8) @(negedge clk);
    hyd_det = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (pos0 !== 24'h0) begin fails++; $display("FAIL reset_pos: got %h, expected 000000", pos0); end
    checks++; if (v0 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", v0); end
    checks++; if (t0 !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b, expected 0", t0); end
    checks++; if (b0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", b0); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (b0 !== 1'b0) begin fails++; $display("FAIL high_lines_no_capture: busy=%b, expected 0", b0); end
    hyd_det = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    drive_ping(0, 40, 10, 100);
    finish_ping();
  endtask

  task automatic test_timeout();
    int c, pulses, pcyc;
    pulses = 0; pcyc = -1;
    @(negedge clk);
    c = cyc;
    hyd_det[0] = 1'b1;
    for (int n = 1; n < 4200; n++) begin
      @(negedge clk);
      if (n == 10) hyd_det[1] = 1'b1;
      if (n == 20) hyd_det[2] = 1'b1;
      if (t0 === 1'b1) begin pulses++; pcyc = cyc; end
    end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL timeout_count: got %0d pulses, expected 1", pulses); end
    checks++; if (pcyc !== c + WINDOW + 1) begin fails++; $display("FAIL timeout_cycle: got %0d, expected %0d", pcyc, c + WINDOW + 1); end
    repeat (HOLDOFF) @(negedge clk);
    checks++; if (b0 !== 1'b0) begin fails++; $display("FAIL timeout_busy_end: got %b, expected 0", b0); end
    checks++; if (pos0 !== {8'h9C, 8'hF6, 8'hD8}) begin fails++; $display("FAIL timeout_pos_held: got %h, expected 9cf6d8", pos0); end
    checks++; if (pos2 !== {8'hE7, 8'hFD, 8'hF6}) begin fails++; $display("FAIL timeout_pos2_held: got %h, expected e7fdf6", pos2); end
    hyd_det = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int kv, bcnt;
    bcnt = 0;
    drive_ping(0, 0, 0, 0);
    kv = cyc + 3;
    while (cyc < kv + HOLDOFF + 5) begin
      @(negedge clk);
      if (cyc >= kv && b0 === 1'b1) bcnt++;
      if (cyc == kv + HOLDOFF / 2) hyd_det = 4'b0000;
      if (cyc == kv + HOLDOFF / 2 + 2) hyd_det = 4'b1111;
      if (cyc == kv + HOLDOFF) begin
        checks++; if (b0 !== 1'b0) begin fails++; $display("FAIL holdoff_release: busy=%b, expected 0", b0); end
      end
    end
    checks++; if (bcnt !== HOLDOFF) begin fails++; $display("FAIL holdoff_busy_len: got %0d, expected %0d", bcnt, HOLDOFF); end
    hyd_det = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_saturate();
    drive_ping(300, 0, 300, 300);
    finish_ping();
  endtask

  task automatic test_enable_drop();
    @(negedge clk); hyd_det[0] = 1'b1;
    repeat (5) @(negedge clk); hyd_det[1] = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (b0 !== 1'b1) begin fails++; $display("FAIL drop_busy_before: got %b, expected 1", b0); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (b0 !== 1'b0) begin fails++; $display("FAIL drop_busy_next: got %b, expected 0", b0); end
    hyd_det = 4'b1111;
    repeat (10) @(negedge clk);
    checks++; if (pos0 !== {8'h00, 8'h00, 8'h7F}) begin fails++; $display("FAIL drop_pos_held: got %h, expected 00007f", pos0); end
    checks++; if (pos2 !== {8'h00, 8'h00, 8'h4B}) begin fails++; $display("FAIL drop_pos2_held: got %h, expected 00004b", pos2); end
    hyd_det = 4'b0000;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (b0 !== 1'b0) begin fails++; $display("FAIL drop_rearm_idle: got %b, expected 0", b0); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); hyd_det[0] = 1'b1;
    repeat (3) @(negedge clk); hyd_det[1] = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (b0 !== 1'b1) begin fails++; $display("FAIL midrst_busy_before: got %b, expected 1", b0); end
    rst = 1'b1;
    #1;
    checks++; if (pos0 !== 24'h0) begin fails++; $display("FAIL midrst_pos: got %h, expected 000000", pos0); end
    checks++; if (b0 !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b, expected 0", b0); end
    @(negedge clk);
    rst = 1'b0;
    hyd_det = 4'b0000;
    repeat (4) @(negedge clk);
    drive_ping(5, 0, 20, 7);
    finish_ping();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_simultaneous();
    test_saturate();
    test_enable_drop();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++; if (sb.size() !== 0) begin fails++; $display("FAIL sb_drained: %0d results never produced", sb.size()); end
    checks++; if (tmo_cnt !== 1) begin fails++; $display("FAIL timeout_total: got %0d, expected 1", tmo_cnt); end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
